// File: rtl/pipe_skid_buffer.sv
// Registered valid/ready stage with a one-entry skid register.
// Every output comes straight from a flop, so the downstream mux sees a stable operand.
module pipe_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [1:0]       count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Handshakes use the registered ready_o/valid_o, never a combinational path.
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;
    assign data_o   = main_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_nxt      = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A squash wins over any handshake; held words are simply abandoned.
        if (flush_i) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            count_o <= 2'd0;
        end else begin
            state   <= state_nxt;
            valid_o <= (state_nxt != EMPTY);
            ready_o <= (state_nxt != FULL);
            count_o <= state_nxt;
            if (load_main_in) begin
                main_q <= data_i;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios plus random traffic against a
// two-deep FIFO reference queue.
module tb_pipe_skid_buffer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [W-1:0] din;
    logic         vld_in;
    logic         rdy_out;
    logic [W-1:0] dout;
    logic         vld_out;
    logic         rdy_in;
    logic [1:0]   cnt;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    pipe_skid_buffer #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .data_i  (din),
        .valid_i (vld_in),
        .ready_o (rdy_out),
        .data_o  (dout),
        .valid_o (vld_out),
        .ready_i (rdy_in),
        .count_o (cnt)
    );

    // Reference: a FIFO holding at most two words; accept when fewer than two held.
    task automatic model_edge();
        bit out_x;
        bit in_x;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            out_x = (mq.size() > 0) && rdy_in;
            in_x  = vld_in && (mq.size() < 2);
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(din);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; vld_in = 1'b1; din = 32'hAA; rdy_in = 1'b0;
        tick();
        tick();
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vld_out); end
        checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_out); end
        checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", dout); end
        rst_n = 1'b1; vld_in = 1'b0;
        tick();
        tick();
        checks++; if (vld_out !== 1'b0 || cnt !== 2'd0) begin errors++; $display("FAIL post_reset_empty got v=%b c=%0d exp v=0 c=0", vld_out, cnt); end
    endtask

    task automatic test_streaming();
        rdy_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vld_in = 1'b1; din = W'(i);
            tick();
            checks++; if (dout !== W'(i) || vld_out !== 1'b1) begin errors++; $display("FAIL stream_data got %h v=%b exp %h v=1", dout, vld_out, i); end
            checks++; if (cnt !== 2'd1 || rdy_out !== 1'b1) begin errors++; $display("FAIL stream_count got c=%0d r=%b exp c=1 r=1", cnt, rdy_out); end
        end
        vld_in = 1'b0;
        tick();
        checks++; if (vld_out !== 1'b0 || cnt !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%b c=%0d exp v=0 c=0", vld_out, cnt); end
    endtask

    task automatic test_backpressure();
        rdy_in = 1'b0;
        vld_in = 1'b1; din = 32'h10; tick();
        vld_in = 1'b1; din = 32'h11; tick();
        checks++; if (cnt !== 2'd2 || rdy_out !== 1'b0) begin errors++; $display("FAIL bp_full got c=%0d r=%b exp c=2 r=0", cnt, rdy_out); end
        vld_in = 1'b1; din = 32'h12; tick();
        checks++; if (cnt !== 2'd2 || dout !== 32'h10) begin errors++; $display("FAIL bp_hold got c=%0d d=%h exp c=2 d=10", cnt, dout); end
        rdy_in = 1'b1; tick();
        checks++; if (dout !== 32'h11 || cnt !== 2'd1) begin errors++; $display("FAIL bp_second got d=%h c=%0d exp d=11 c=1", dout, cnt); end
        tick();
        checks++; if (dout !== 32'h12 || vld_out !== 1'b1) begin errors++; $display("FAIL bp_third got d=%h v=%b exp d=12 v=1", dout, vld_out); end
        vld_in = 1'b0; tick();
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b exp 0", vld_out); end
    endtask

    task automatic test_flush_full();
        rdy_in = 1'b0;
        vld_in = 1'b1; din = 32'hA0; tick();
        din = 32'hA1; tick();
        checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL flush_pre got c=%0d exp 2", cnt); end
        flush = 1'b1; vld_in = 1'b1; din = 32'h55; tick();
        flush = 1'b0; vld_in = 1'b0;
        checks++; if (vld_out !== 1'b0 || cnt !== 2'd0 || rdy_out !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%b c=%0d r=%b exp v=0 c=0 r=1", vld_out, cnt, rdy_out); end
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL flush_leak got v=%b d=%h exp v=0", vld_out, dout); end
        end
    endtask

    task automatic test_reset_mid();
        rdy_in = 1'b0; vld_in = 1'b1; din = 32'h3C; tick();
        checks++; if (cnt !== 2'd1 || dout !== 32'h3C) begin errors++; $display("FAIL rmid_pre got c=%0d d=%h exp c=1 d=3c", cnt, dout); end
        vld_in = 1'b0; rst_n = 1'b0; tick();
        checks++; if (vld_out !== 1'b0 || dout !== 32'h0 || cnt !== 2'd0) begin errors++; $display("FAIL rmid_reset got v=%b d=%h c=%0d exp v=0 d=0 c=0", vld_out, dout, cnt); end
        rst_n = 1'b1; rdy_in = 1'b1; vld_in = 1'b1; din = 32'h7E; tick();
        checks++; if (vld_out !== 1'b1 || dout !== 32'h7E) begin errors++; $display("FAIL rmid_first got v=%b d=%h exp v=1 d=7e", vld_out, dout); end
        vld_in = 1'b0; tick();
    endtask

    task automatic test_random();
        logic [W-1:0] prev_d;
        bit           prev_stall;
        prev_stall = 1'b0;
        prev_d = '0;
        for (int c = 0; c < 10000; c++) begin
            vld_in = ($urandom_range(0, 3) != 0);
            rdy_in = ($urandom_range(0, 2) != 0);
            din    = $urandom;
            flush  = ($urandom_range(0, 127) == 0);
            prev_stall = vld_out && !rdy_in && !flush;
            prev_d     = dout;
            tick();
            checks++; if (vld_out !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, vld_out, mq.size() > 0); end
            checks++; if (rdy_out !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, rdy_out, mq.size() < 2); end
            checks++; if (cnt !== 2'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, cnt, mq.size()); end
            if (mq.size() > 0) begin
                checks++; if (dout !== mq[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, dout, mq[0]); end
            end
            if (prev_stall) begin
                checks++; if (vld_out !== 1'b1 || dout !== prev_d) begin errors++; $display("FAIL rnd_stable cyc %0d got v=%b d=%h exp v=1 d=%h", c, vld_out, dout, prev_d); end
            end
        end
        flush = 1'b0; vld_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; vld_in = 1'b0; din = '0; rdy_in = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
